me_modadd_ws: RTL
=================

ME_MODADD_WS -- requirements
Module: me_modadd_ws

Interface
REQ-001 Parameter K, default 128, word width in bits.
REQ-002 Parameter N, default 32, maximum operand length in words (operand width up to K*N).
REQ-003 Parameter LW, default $clog2(N+1), width of the len port.
REQ-004 Timing: one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 start  input  1  one-cycle request; samples mode and len.
REQ-008 mode  input  1  0 = (x+y) mod m, 1 = (x-y) mod m.
REQ-009 len  input  LW  operand length in words, legal range 1..N.
REQ-010 in_x  input  K  x word, least significant word first.
REQ-011 in_y  input  K  y word, same index as in_x.
REQ-012 in_m  input  K  modulus word, same index as in_x.
REQ-013 in_valid  input  1  in_x/in_y/in_m valid this cycle.
REQ-014 out_word  output  K  result word, least significant word first.
REQ-015 out_valid  output  1  out_word valid.
REQ-016 out_last  output  1  marks the final result word.
REQ-017 busy  output  1  high outside IDLE.
REQ-018 err  output  1  one-cycle pulse on an illegal len.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, DECIDE and OUT.
REQ-020 In IDLE, start with 1<=len<=N SHALL latch mode and len, clear word index, carry and borrow, and enter LOAD.
REQ-021 In IDLE, start with len==0 or len>N SHALL pulse err for one cycle and remain in IDLE.
REQ-022 start outside IDLE, and in_valid outside LOAD, SHALL be ignored.
REQ-023 In LOAD, each cycle with in_valid high SHALL consume one word; gaps in in_valid are allowed.
REQ-024 Per word i in add mode: S[i] = x+y+c (carry c out); T[i] = S[i]-m-b (borrow b out).
REQ-025 Per word i in sub mode: S[i] = x-y-b (borrow b out); T[i] = S[i]+m+c (carry c out).
REQ-026 S and T SHALL each be buffered as N words of K bits.
REQ-027 After word len-1 is consumed, the FSM SHALL enter DECIDE for exactly one cycle.
REQ-028 DECIDE, add mode: select T if final sum carry==1 or final T borrow==0, else select S.
REQ-029 DECIDE, sub mode: select T if final S borrow==1, else select S.
REQ-030 OUT SHALL drive len consecutive words of the selected buffer, index 0 first, with out_valid high throughout.
REQ-031 The first out_valid cycle SHALL be the second cycle after the cycle in which the last input word is sampled.
REQ-032 out_last SHALL be high only with word len-1; the following cycle returns to IDLE.
REQ-033 There is no output backpressure.
REQ-034 out_word SHALL be 0 whenever out_valid is low.
REQ-035 Inputs are assumed to satisfy x<m and y<m; outputs are unspecified otherwise, but FSM sequencing SHALL be unaffected.
REQ-036 A start accepted in the cycle after out_last SHALL be honoured.

Reset
REQ-037 rst SHALL force IDLE immediately and asynchronously.
REQ-038 Under reset, out_word=0, out_valid=0, out_last=0, busy=0, err=0, and carry, borrow and index all 0.
REQ-039 Buffer contents need not be reset.
REQ-040 Reset asserted mid-LOAD or mid-OUT SHALL abort the operation with no further out_valid; the next start after release SHALL operate normally.

Verification (K=8, N=4 unless noted)
REQ-041 add, len=2, x=0x00FF, y=0x0001, m=0x0101 -> out 0x00, 0x01, out_last on the 2nd word.
REQ-042 add, len=2, x=0x0100, y=0x0001, m=0x0101 -> out 0x00, 0x00.
REQ-043 add, len=2, x=0xFFFE, y=0xFFFE, m=0xFFFF -> carry path, out 0xFD, 0xFF.
REQ-044 sub, len=2, x=0x0001, y=0x0002, m=0x0101 -> out 0x00, 0x01; repeat with in_valid gaps -> identical output and latency per REQ-031.
REQ-045 start with len=0, then with len=5 -> one err pulse each, busy stays 0; rst mid-LOAD -> no out_valid, next legal start correct.
REQ-046 K=128, N=32, len=32, 1000 random add/sub operations -> every output matches a 4096-bit reference model.

Source files
------------

// File: rtl/me_modadd_ws.sv
// me_modadd_ws: word-serial modular add/subtract.
// Operands stream in least significant word first. Both candidate results
// are built in parallel: S is the plain sum/difference and T is S corrected
// by the modulus. Once the final carry and borrow are known, one of the two
// buffers is streamed out.
module me_modadd_ws #(
  parameter int K  = 128,
  parameter int N  = 32,
  parameter int LW = $clog2(N+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [LW-1:0] len,
  input  logic [K-1:0]  in_x,
  input  logic [K-1:0]  in_y,
  input  logic [K-1:0]  in_m,
  input  logic          in_valid,
  output logic [K-1:0]  out_word,
  output logic          out_valid,
  output logic          out_last,
  output logic          busy,
  output logic          err
);

  // Buffer address width. The word index register is LW bits wide so it
  // can be compared directly against len; only its low IW bits address
  // the buffers.
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DECIDE, OUT} state_t;

  state_t        state_q, state_d;
  logic          mode_q, mode_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic          borrow_q, borrow_d;
  logic          sel_q, sel_d;
  logic          err_q, err_d;
  logic          wr_en;

  logic [K-1:0]  s_mem [N];
  logic [K-1:0]  t_mem [N];

  logic [K:0]    s_ext, t_ext;
  logic          c_out, b_out;
  logic          last_word;
  logic          len_ok;

  assign last_word = (idx_q == len_q - LW'(1));
  assign len_ok    = (len != '0) && (len <= LW'(N));

  // Per-word arithmetic. The extra top bit of each K+1 bit result is the
  // carry (for an addition) or the borrow (for a subtraction).
  always_comb begin
    s_ext = '0;
    t_ext = '0;
    c_out = 1'b0;
    b_out = 1'b0;
    if (!mode_q) begin
      s_ext = {1'b0, in_x} + {1'b0, in_y} + {{K{1'b0}}, carry_q};
      t_ext = {1'b0, s_ext[K-1:0]} - {1'b0, in_m} - {{K{1'b0}}, borrow_q};
      c_out = s_ext[K];
      b_out = t_ext[K];
    end else begin
      s_ext = {1'b0, in_x} - {1'b0, in_y} - {{K{1'b0}}, borrow_q};
      t_ext = {1'b0, s_ext[K-1:0]} + {1'b0, in_m} + {{K{1'b0}}, carry_q};
      c_out = t_ext[K];
      b_out = s_ext[K];
    end
  end

  // Next-state logic for the sequencer.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    len_d    = len_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    sel_d    = sel_q;
    err_d    = 1'b0;
    wr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            mode_d   = mode;
            len_d    = len;
            idx_d    = '0;
            carry_d  = 1'b0;
            borrow_d = 1'b0;
            state_d  = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (in_valid) begin
          wr_en    = 1'b1;
          carry_d  = c_out;
          borrow_d = b_out;
          if (last_word) begin
            idx_d   = '0;
            state_d = DECIDE;
          end else begin
            idx_d = idx_q + LW'(1);
          end
        end
      end
      DECIDE: begin
        // Add: S >= m exactly when the sum overflowed or S-m did not borrow.
        // Sub: x-y went negative, so the m-corrected value is the answer.
        sel_d   = mode_q ? borrow_q : (carry_q | ~borrow_q);
        state_d = OUT;
      end
      OUT: begin
        if (last_word) begin
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + LW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      len_q    <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      sel_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      sel_q    <= sel_d;
      err_q    <= err_d;
    end
  end

  // Candidate result buffers. They have no reset because every word is
  // rewritten before it is read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      s_mem[idx_q[IW-1:0]] <= s_ext[K-1:0];
      t_mem[idx_q[IW-1:0]] <= t_ext[K-1:0];
    end
  end

  assign out_valid = (state_q == OUT);
  assign out_last  = out_valid && last_word;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;
  assign out_word  = !out_valid ? '0 :
                     (sel_q ? t_mem[idx_q[IW-1:0]] : s_mem[idx_q[IW-1:0]]);

endmodule
